// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : adc_pkg
//  Brief   : Shared ADC word widths and the saturating magnitude helper.
//  Rev     : 1.0  initial release
// ============================================================================
package adc_pkg;

    localparam int ADC_W = 16;
    localparam int ABS_W = 15;
    localparam logic [ABS_W-1:0] ABS_MAX = 15'h7FFF;

    // Two's complement to magnitude; -32768 has no 15-bit magnitude so it pins to ABS_MAX.
    function automatic logic [ABS_W-1:0] abs_sat(input logic [ADC_W-1:0] x);
        logic [ADC_W-1:0] w_neg;
        w_neg = ~x + ADC_W'(1);
        if (!x[ADC_W-1])
            abs_sat = x[ABS_W-1:0];
        else if (x == {1'b1, {ABS_W{1'b0}}})
            abs_sat = ABS_MAX;
        else
            abs_sat = w_neg[ABS_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_stretch.sv
`default_nettype none
// ============================================================================
//  Module  : pulse_stretch
//  Brief   : Retriggerable hold counter; out_o high for HOLD_CYCLES after trig_i.
//  Rev     : 1.0  initial release
// ============================================================================
module pulse_stretch #(
    parameter int HOLD_CYCLES = 1000
) (
    input  logic clka,
    input  logic local_reset,
    input  logic trig_i,
    output logic out_o
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] c_hold_load = CW'(HOLD_CYCLES);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clka or posedge local_reset) begin
        if (local_reset)
            r_cnt <= '0;
        else if (trig_i)
            r_cnt <= c_hold_load;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - CW'(1);
    end

    assign out_o = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/adc_peak_monitor.sv
`default_nettype none
// ============================================================================
//  Module  : adc_peak_monitor
//  Brief   : Windowed peak |x| and clip count of the ADC stream, plus stretched
//            and sticky overload indicators.
//  Rev     : 1.0  initial release
// ============================================================================
module adc_peak_monitor
    import adc_pkg::*;
#(
    parameter int WIN_LOG2    = 12,
    parameter int CNT_W       = 16,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic             clka,
    input  logic             local_reset,
    input  logic [ADC_W-1:0] adc_i,
    input  logic             adc_en_i,
    input  logic             adc_ovr_i,
    input  logic [ABS_W-1:0] thresh_i,
    input  logic             clr_i,
    output logic [ABS_W-1:0] peak_o,
    output logic [CNT_W-1:0] clip_cnt_o,
    output logic             win_valid_o,
    output logic             ovl_o,
    output logic             ovl_sticky_o
);

    localparam logic [WIN_LOG2-1:0] c_win_last = '1;
    localparam logic [CNT_W-1:0]    c_cnt_max  = '1;

    logic [ABS_W-1:0]    w_abs;
    logic                w_evt;
    logic [ABS_W-1:0]    r_abs;
    logic                r_evt;
    logic                r_v1;

    logic [ABS_W-1:0]    w_pk_next;
    logic [CNT_W-1:0]    w_clip_next;
    logic [ABS_W-1:0]    r_pk_acc;
    logic [CNT_W-1:0]    r_clip_acc;
    logic [WIN_LOG2-1:0] r_win_cnt;
    logic [ABS_W-1:0]    r_peak;
    logic [CNT_W-1:0]    r_clip_cnt;
    logic                r_win_valid;
    logic                r_sticky;
    logic                w_ovl_evt;

    assign w_abs = abs_sat(adc_i);
    assign w_evt = (w_abs >= thresh_i) | adc_ovr_i;

    // Stage 1: magnitude and event flag; payload holds across enable gaps.
    always_ff @(posedge clka or posedge local_reset) begin
        if (local_reset) begin
            r_abs <= '0;
            r_evt <= 1'b0;
            r_v1  <= 1'b0;
        end else begin
            r_v1 <= adc_en_i;
            if (adc_en_i) begin
                r_abs <= w_abs;
                r_evt <= w_evt;
            end
        end
    end

    assign w_pk_next   = (r_abs > r_pk_acc) ? r_abs : r_pk_acc;
    assign w_clip_next = (r_evt && (r_clip_acc != c_cnt_max)) ? r_clip_acc + CNT_W'(1)
                                                              : r_clip_acc;

    // Stage 2: window accumulation; the closing sample folds straight into the outputs.
    always_ff @(posedge clka or posedge local_reset) begin
        if (local_reset) begin
            r_pk_acc    <= '0;
            r_clip_acc  <= '0;
            r_win_cnt   <= '0;
            r_peak      <= '0;
            r_clip_cnt  <= '0;
            r_win_valid <= 1'b0;
        end else begin
            r_win_valid <= 1'b0;
            if (r_v1) begin
                r_win_cnt <= r_win_cnt + WIN_LOG2'(1);
                if (r_win_cnt == c_win_last) begin
                    r_peak      <= w_pk_next;
                    r_clip_cnt  <= w_clip_next;
                    r_win_valid <= 1'b1;
                    r_pk_acc    <= '0;
                    r_clip_acc  <= '0;
                end else begin
                    r_pk_acc   <= w_pk_next;
                    r_clip_acc <= w_clip_next;
                end
            end
        end
    end

    assign w_ovl_evt = r_v1 & r_evt;

    // A fresh event outranks a simultaneous clear so no overload is ever lost.
    always_ff @(posedge clka or posedge local_reset) begin
        if (local_reset)
            r_sticky <= 1'b0;
        else if (w_ovl_evt)
            r_sticky <= 1'b1;
        else if (clr_i)
            r_sticky <= 1'b0;
    end

    pulse_stretch #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_ovl_stretch (
        .clka        (clka),
        .local_reset (local_reset),
        .trig_i      (w_ovl_evt),
        .out_o       (ovl_o)
    );

    assign peak_o       = r_peak;
    assign clip_cnt_o   = r_clip_cnt;
    assign win_valid_o  = r_win_valid;
    assign ovl_sticky_o = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_adc_peak_monitor.sv
`default_nettype none
// ============================================================================
//  Module  : tb_adc_peak_monitor
//  Brief   : Randomized and directed bench for adc_peak_monitor against a
//            window/queue based reference model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_adc_peak_monitor;

    localparam int WIN_LOG2    = 4;
    localparam int CNT_W       = 3;
    localparam int HOLD_CYCLES = 8;
    localparam int WIN         = 1 << WIN_LOG2;
    localparam int CLIP_MAX    = (1 << CNT_W) - 1;
    localparam int VW          = 15 + CNT_W + 3;

    logic              clka = 1'b0;
    logic              local_reset = 1'b1;
    logic [15:0]       adc_i = '0;
    logic              adc_en_i = 1'b0;
    logic              adc_ovr_i = 1'b0;
    logic [14:0]       thresh_i = '0;
    logic              clr_i = 1'b0;
    logic [14:0]       peak_o;
    logic [CNT_W-1:0]  clip_cnt_o;
    logic              win_valid_o;
    logic              ovl_o;
    logic              ovl_sticky_o;

    adc_peak_monitor #(
        .WIN_LOG2    (WIN_LOG2),
        .CNT_W       (CNT_W),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clka         (clka),
        .local_reset  (local_reset),
        .adc_i        (adc_i),
        .adc_en_i     (adc_en_i),
        .adc_ovr_i    (adc_ovr_i),
        .thresh_i     (thresh_i),
        .clr_i        (clr_i),
        .peak_o       (peak_o),
        .clip_cnt_o   (clip_cnt_o),
        .win_valid_o  (win_valid_o),
        .ovl_o        (ovl_o),
        .ovl_sticky_o (ovl_sticky_o)
    );

    always #5 clka = ~clka;

    // Reference model state: input history per cycle, current window as queues.
    int               cyc = 0;
    int               rst_base = 0;
    int               h_abs [4096];
    bit               h_en  [4096];
    bit               h_evt [4096];
    bit               h_clr [4096];
    int               q_abs [$];
    bit               q_evt [$];
    logic [14:0]      e_peak = '0;
    logic [CNT_W-1:0] e_clip = '0;
    logic             e_valid = 1'b0;
    logic             e_ovl = 1'b0;
    logic             e_sticky = 1'b0;
    bit               have_ev = 1'b0;
    int               last_ev = 0;
    int               n_vec = 0;
    int               n_err = 0;

    wire [VW-1:0] w_obs = {peak_o, clip_cnt_o, win_valid_o, ovl_o, ovl_sticky_o};
    wire [VW-1:0] w_exp = {e_peak, e_clip, e_valid, e_ovl, e_sticky};

    task automatic model_clear();
        q_abs.delete();
        q_evt.delete();
        e_peak = '0; e_clip = '0; e_valid = 1'b0; e_ovl = 1'b0; e_sticky = 1'b0;
        have_ev = 1'b0;
    endtask

    // A sample driven in cycle k is reflected in the outputs after edge k+2.
    task automatic model_edge();
        int  k;
        bit  ev;
        bit  clr;
        e_valid = 1'b0;
        if (local_reset) begin
            model_clear();
            return;
        end
        k   = (cyc - 2) & 4095;
        ev  = (cyc - 2 >= rst_base) && h_evt[k];
        clr = (cyc - 1 >= rst_base) && h_clr[(cyc - 1) & 4095];
        if ((cyc - 2 >= rst_base) && h_en[k]) begin
            q_abs.push_back(h_abs[k]);
            q_evt.push_back(h_evt[k]);
            if (q_abs.size() == WIN) begin
                int pk;
                int nc;
                pk = 0;
                nc = 0;
                foreach (q_abs[i]) begin
                    if (q_abs[i] > pk) pk = q_abs[i];
                    if (q_evt[i]) nc++;
                end
                e_peak  = 15'(pk);
                e_clip  = CNT_W'((nc > CLIP_MAX) ? CLIP_MAX : nc);
                e_valid = 1'b1;
                q_abs.delete();
                q_evt.delete();
            end
        end
        if (ev) begin
            have_ev  = 1'b1;
            last_ev  = cyc;
            e_sticky = 1'b1;
        end else if (clr) begin
            e_sticky = 1'b0;
        end
        e_ovl = have_ev && (cyc - last_ev < HOLD_CYCLES);
    endtask

    task automatic step(input logic en, input logic [15:0] a, input logic ovr,
                        input logic [14:0] th, input logic clr);
        int k;
        int s;
        adc_en_i = en; adc_i = a; adc_ovr_i = ovr; thresh_i = th; clr_i = clr;
        k = cyc & 4095;
        s = $signed(a);
        if (s < 0) s = -s;
        if (s > 32767) s = 32767;
        h_en[k]  = en;
        h_abs[k] = s;
        h_evt[k] = en && ((s >= int'(th)) || ovr);
        h_clr[k] = clr;
        @(posedge clka);
        cyc++;
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        local_reset = 1'b1;
        model_clear();
        step(1'b0, 16'h0, 1'b0, 15'h0, 1'b0);
        local_reset = 1'b0;
        rst_base = cyc;
    endtask

    function automatic logic [15:0] rand_adc();
        case ($urandom_range(0, 9))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, rand_adc(), ($urandom_range(0, 7) == 0), 15'($urandom), 1'b0);
            n_vec++;
            if (w_obs !== w_exp) begin
                n_err++;
                $display("FAIL reset_pre cyc=%0d got=%h expected=%h", cyc, w_obs, w_exp);
            end
        end
        local_reset = 1'b1;
        model_clear();
        #1;
        n_vec++;
        if (w_obs !== '0) begin
            n_err++;
            $display("FAIL reset_async cyc=%0d got=%h expected=0", cyc, w_obs);
        end
        step(1'b1, rand_adc(), 1'b1, 15'h0, 1'b0);
        local_reset = 1'b0;
        rst_base = cyc;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, rand_adc(), ($urandom_range(0, 7) == 0), 15'($urandom), 1'b0);
            n_vec++;
            if (w_obs !== w_exp) begin
                n_err++;
                $display("FAIL reset_post cyc=%0d got=%h expected=%h", cyc, w_obs, w_exp);
            end
        end
    endtask

    task automatic test_ramp();
        do_reset();
        for (int i = 0; i < WIN; i++) begin
            step(1'b1, 16'(i), 1'b0, 15'd10, 1'b0);
            n_vec++;
            if (w_obs !== w_exp) begin
                n_err++;
                $display("FAIL ramp cyc=%0d got=%h expected=%h", cyc, w_obs, w_exp);
            end
        end
        step(1'b0, 16'h0, 1'b0, 15'd10, 1'b0);
        n_vec++;
        if (win_valid_o !== 1'b1 || peak_o !== 15'd15 || clip_cnt_o !== CNT_W'(6)) begin
            n_err++;
            $display("FAIL ramp_result got v=%b pk=%0d clip=%0d expected v=1 pk=15 clip=6",
                     win_valid_o, peak_o, clip_cnt_o);
        end
        step(1'b0, 16'h0, 1'b0, 15'd10, 1'b0);
        n_vec++;
        if (w_obs !== w_exp) begin
            n_err++;
            $display("FAIL ramp_hold cyc=%0d got=%h expected=%h", cyc, w_obs, w_exp);
        end
    endtask

    task automatic test_fullscale();
        int pos;
        do_reset();
        pos = $urandom_range(0, WIN - 1);
        for (int i = 0; i < WIN; i++) begin
            step(1'b1, (i == pos) ? 16'h8000 : 16'($signed($urandom_range(0, 2000)) - 1000),
                 1'b0, 15'h7FFF, 1'b0);
            n_vec++;
            if (w_obs !== w_exp) begin
                n_err++;
                $display("FAIL fullscale cyc=%0d got=%h expected=%h", cyc, w_obs, w_exp);
            end
        end
        step(1'b0, 16'h0, 1'b0, 15'h7FFF, 1'b0);
        n_vec++;
        if (win_valid_o !== 1'b1 || peak_o !== 15'h7FFF || clip_cnt_o !== CNT_W'(1)) begin
            n_err++;
            $display("FAIL fullscale_result got v=%b pk=%h clip=%0d expected v=1 pk=7fff clip=1",
                     win_valid_o, peak_o, clip_cnt_o);
        end
    endtask

    task automatic test_gaps();
        int nv;
        nv = 0;
        do_reset();
        for (int i = 0; i < 34; i++) begin
            step((i < 32) && (i % 2 == 0), rand_adc(), 1'b0, 15'($urandom), 1'b0);
            if (win_valid_o === 1'b1) nv++;
            n_vec++;
            if (w_obs !== w_exp) begin
                n_err++;
                $display("FAIL gaps cyc=%0d got=%h expected=%h", cyc, w_obs, w_exp);
            end
        end
        n_vec++;
        if (nv !== 1) begin
            n_err++;
            $display("FAIL gaps_windows got=%0d expected=1", nv);
        end
    endtask

    task automatic test_overload();
        int nh;
        do_reset();
        nh = 0;
        for (int i = 0; i < 20; i++) begin
            step(i == 0, 16'h0, i == 0, 15'h7FFF, 1'b0);
            if (ovl_o === 1'b1) nh++;
            n_vec++;
            if (w_obs !== w_exp) begin
                n_err++;
                $display("FAIL ovl_single cyc=%0d got=%h expected=%h", cyc, w_obs, w_exp);
            end
        end
        n_vec++;
        if (nh !== HOLD_CYCLES) begin
            n_err++;
            $display("FAIL ovl_single_len got=%0d expected=%0d", nh, HOLD_CYCLES);
        end
        nh = 0;
        for (int i = 0; i < 30; i++) begin
            step(i == 0 || i == 5, 16'h0, i == 0 || i == 5, 15'h7FFF, 1'b0);
            if (ovl_o === 1'b1) nh++;
            n_vec++;
            if (w_obs !== w_exp) begin
                n_err++;
                $display("FAIL ovl_retrig cyc=%0d got=%h expected=%h", cyc, w_obs, w_exp);
            end
        end
        n_vec++;
        if (nh !== HOLD_CYCLES + 5) begin
            n_err++;
            $display("FAIL ovl_retrig_len got=%0d expected=%0d", nh, HOLD_CYCLES + 5);
        end
    endtask

    task automatic test_sticky();
        do_reset();
        step(1'b1, 16'h0, 1'b1, 15'h7FFF, 1'b0);
        step(1'b0, 16'h0, 1'b0, 15'h7FFF, 1'b1);
        n_vec++;
        if (ovl_sticky_o !== 1'b1 || w_obs !== w_exp) begin
            n_err++;
            $display("FAIL sticky_evt_wins got=%b expected=1 (vec %h vs %h)",
                     ovl_sticky_o, w_obs, w_exp);
        end
        step(1'b0, 16'h0, 1'b0, 15'h7FFF, 1'b1);
        n_vec++;
        if (ovl_sticky_o !== 1'b0 || w_obs !== w_exp) begin
            n_err++;
            $display("FAIL sticky_clear got=%b expected=0 (vec %h vs %h)",
                     ovl_sticky_o, w_obs, w_exp);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < WIN + 1; i++) begin
            step(i < WIN, rand_adc(), 1'b0, 15'h0, 1'b0);
            n_vec++;
            if (w_obs !== w_exp) begin
                n_err++;
                $display("FAIL saturate cyc=%0d got=%h expected=%h", cyc, w_obs, w_exp);
            end
        end
        n_vec++;
        if (win_valid_o !== 1'b1 || clip_cnt_o !== CNT_W'(CLIP_MAX)) begin
            n_err++;
            $display("FAIL saturate_result got v=%b clip=%0d expected v=1 clip=%0d",
                     win_valid_o, clip_cnt_o, CLIP_MAX);
        end
    endtask

    task automatic test_random();
        logic [14:0] th;
        th = 15'($urandom);
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                case ($urandom_range(0, 2))
                    0:       th = 15'h0;
                    1:       th = 15'h7FFF;
                    default: th = 15'($urandom);
                endcase
            end
            step($urandom_range(0, 3) != 0, rand_adc(), $urandom_range(0, 15) == 0, th,
                 $urandom_range(0, 19) == 0);
            n_vec++;
            if (w_obs !== w_exp) begin
                n_err++;
                $display("FAIL random cyc=%0d got=%h expected=%h", cyc, w_obs, w_exp);
            end
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_ramp();
        test_fullscale();
        test_gaps();
        test_overload();
        test_sticky();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
